// File: rtl/dim_query_serializer.sv
// Parallel-to-serial transmitter; bit order and terminal count come from array queries.
// Optional even-parity trailer beat: define DIM_QUERY_SERIALIZER_PARITY_EN.
module dim_query_serializer #(
  parameter int WIDTH     = 6,
  parameter int ASCENDING = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic                     ser_out,
  output logic [$clog2(WIDTH)-1:0] ser_index,
  output logic                     ser_last
);

  localparam int IW = $clog2(WIDTH);
`ifdef DIM_QUERY_SERIALIZER_PARITY_EN
  localparam int CW = $clog2(WIDTH + 1);
`else
  localparam int CW = $clog2(WIDTH);
`endif

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t r_state;

  logic [((ASCENDING != 0) ? 0 : WIDTH-1) :
         ((ASCENDING != 0) ? WIDTH-1 : 0)] r_shreg;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_out;
  logic          r_valid;
  logic          r_last;
  logic          w_term;
  logic          w_nxt_last;

  assign in_ready  = (r_state == S_IDLE);
  assign ser_valid = r_valid;
  assign ser_out   = r_out;
  assign ser_index = r_idx;
  assign ser_last  = r_last;

  always_comb begin
    w_cnt_nxt  = r_cnt + CW'(1);
    w_term     = 1'b0;
    w_nxt_last = 1'b0;
`ifdef DIM_QUERY_SERIALIZER_PARITY_EN
    case (r_cnt)
      CW'($size(r_shreg)): w_term = 1'b1;
      default: ;
    endcase
    case (w_cnt_nxt)
      CW'($size(r_shreg)): w_nxt_last = 1'b1;
      default: ;
    endcase
`else
    case (r_cnt)
      CW'($size(r_shreg)-1): w_term = 1'b1;
      default: ;
    endcase
    case (w_cnt_nxt)
      CW'($size(r_shreg)-1): w_nxt_last = 1'b1;
      default: ;
    endcase
`endif
    // Walk from $left toward $right whatever the declared direction.
    if ($left(r_shreg) > $right(r_shreg)) begin
      w_idx_nxt = r_idx - IW'(1);
    end else begin
      w_idx_nxt = r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_SEND;
            r_shreg <= in_data;
            r_cnt   <= '0;
            r_idx   <= IW'($left(r_shreg));
            r_out   <= in_data[$left(in_data)];
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        S_SEND: begin
          if (ser_ready) begin
            if (w_term) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_cnt  <= w_cnt_nxt;
              r_last <= w_nxt_last;
`ifdef DIM_QUERY_SERIALIZER_PARITY_EN
              if (w_nxt_last) begin
                r_idx <= '0;
                r_out <= ^r_shreg;
              end else begin
                r_idx <= w_idx_nxt;
                r_out <= r_shreg[w_idx_nxt];
              end
`else
              r_idx <= w_idx_nxt;
              r_out <= r_shreg[w_idx_nxt];
`endif
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dim_query_serializer.sv
// Directed bench: descending and ascending instances driven in lockstep.
// Parity expectations follow DIM_QUERY_SERIALIZER_PARITY_EN.
module tb_dim_query_serializer;

`ifdef DIM_QUERY_SERIALIZER_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_data;
  logic       ser_ready;

  logic       rdy_a, val_a, out_a, last_a;
  logic [2:0] idx_a;
  logic       rdy_b, val_b, out_b, last_b;
  logic [2:0] idx_b;

  int n_chk;
  int n_fail;

  logic g_oa [0:15];
  logic g_ob [0:15];
  logic g_la [0:15];
  logic g_lb [0:15];
  int   g_ia [0:15];
  int   g_ib [0:15];

  dim_query_serializer #(.WIDTH(6), .ASCENDING(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .ser_valid(val_a), .ser_ready(ser_ready),
    .ser_out(out_a), .ser_index(idx_a), .ser_last(last_a)
  );

  dim_query_serializer #(.WIDTH(6), .ASCENDING(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .ser_valid(val_b), .ser_ready(ser_ready),
    .ser_out(out_b), .ser_index(idx_b), .ser_last(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [5:0] d, input bit stall,
                          input bit pulse, input logic par,
                          input string tag);
    bit   done;
    bit   held;
    int   nb;
    logic h_oa, h_ob, h_la;
    logic [2:0] h_ia, h_ib;
    logic e_o;
    int   e_ia, e_ib;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = d;
    ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    done = 0;
    held = 0;
    nb   = 0;
    h_oa = 0; h_ob = 0; h_la = 0; h_ia = 0; h_ib = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      ser_ready = stall ? (k % 3 == 0) : 1'b1;
      if (pulse) begin
        in_valid = (k == 2);
        in_data  = (k == 2) ? 6'h3f : d;
      end
      @(negedge clk);
      if (held) begin
        chk({tag, "_hold_out"}, out_a, h_oa);
        chk({tag, "_hold_outb"}, out_b, h_ob);
        chk({tag, "_hold_ia"}, idx_a, h_ia);
        chk({tag, "_hold_ib"}, idx_b, h_ib);
        chk({tag, "_hold_last"}, last_a, h_la);
      end
      held = 0;
      if (val_a && ser_ready) begin
        if (nb < 16) begin
          g_oa[nb] = out_a;
          g_ob[nb] = out_b;
          g_la[nb] = last_a;
          g_lb[nb] = last_b;
          g_ia[nb] = int'(idx_a);
          g_ib[nb] = int'(idx_b);
        end
        nb++;
        if (last_a) done = 1;
      end else if (val_a) begin
        held = 1;
        h_oa = out_a; h_ob = out_b; h_la = last_a;
        h_ia = idx_a; h_ib = idx_b;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_in_ready_after"}, rdy_a, 1);
    chk({tag, "_valid_after"}, val_a, 0);
    chk({tag, "_beats"}, nb, NB);
    for (int i = 0; i < NB && i < nb; i++) begin
      e_o  = (i < 6) ? d[5-i] : par;
      e_ia = (i < 6) ? 5 - i : 0;
      e_ib = (i < 6) ? i : 0;
      chk($sformatf("%s_out%0d", tag, i), g_oa[i], e_o);
      chk($sformatf("%s_outb%0d", tag, i), g_ob[i], e_o);
      chk($sformatf("%s_ia%0d", tag, i), g_ia[i], e_ia);
      chk($sformatf("%s_ib%0d", tag, i), g_ib[i], e_ib);
      chk($sformatf("%s_last%0d", tag, i), g_la[i], (i == NB - 1));
      chk($sformatf("%s_lastb%0d", tag, i), g_lb[i], (i == NB - 1));
    end
  endtask

  initial begin
    bit extra;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    ser_ready = 1'b0;
    #2;
    chk("rst_in_ready", rdy_a, 1);
    chk("rst_valid", val_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_index", idx_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_valid_b", val_b, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_word(6'b101100, 0, 0, 1'b1, "basic");
    run_word(6'b011001, 1, 0, 1'b1, "stall");
    run_word(6'b000001, 0, 1, 1'b1, "ignore");

    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (val_a || val_b) extra = 1;
    end
    chk("ignore_no_extra_word", extra, 0);

    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = 6'b110101;
    ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", val_a, 0);
    chk("midrst_in_ready", rdy_a, 1);
    chk("midrst_valid_b", val_b, 0);
    chk("midrst_index", idx_a, 0);
    chk("midrst_out", out_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(6'b100000, 0, 0, 1'b1, "after_rst");

`ifdef DIM_QUERY_SERIALIZER_PARITY_EN
    run_word(6'b101101, 0, 0, 1'b0, "par_zero");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
